// File: rtl/vdc_vram_port.sv
// VRAM port arbiter: shares one VRAM access slot per cycle between display fetches and a
// host register interface (MAWR/MARR/data/INC), with display priority bounded by a starvation counter.
module vdc_vram_port #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic [1:0]        cpu_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_drop,
  input  logic              disp_req,
  input  logic [DATA_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [DATA_W-1:0] MA,
  output logic              re,
  output logic              we,
  output logic [DATA_W-1:0] MD_in,
  input  logic [DATA_W-1:0] MD_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FLIGHT = 2'd2} state_t;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;

  localparam logic [1:0] SEL_MAWR = 2'd0;
  localparam logic [1:0] SEL_MARR = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;
  localparam logic [1:0] SEL_INC  = 2'd3;

  function automatic logic [DATA_W-1:0] step_decode(input logic [1:0] code);
    case (code)
      2'b00:   step_decode = DATA_W'(1);
      2'b01:   step_decode = DATA_W'(32);
      2'b10:   step_decode = DATA_W'(64);
      default: step_decode = DATA_W'(128);
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mawr, marr, step, wdata_q;
  logic                op_wr_q;
  logic [2:0]          starv;
  logic [1:0]          tag_p0, tag_p1;
  logic                armed_q;

  logic                busy, cpu_pend, rd_strobe, host_q;
  logic                acc_wr, acc_rd, drop_nxt;
  logic                grant_disp, grant_cpu;
  logic [DATA_W-1:0]   cpu_addr;

  always_comb begin
    busy       = (state_q != IDLE);
    cpu_pend   = (state_q == PEND);
    rd_strobe  = cpu_rd && (cpu_sel == SEL_DATA);
    host_q     = cpu_wr && ((cpu_sel == SEL_MARR) || (cpu_sel == SEL_DATA));
    acc_wr     = host_q && !busy;
    acc_rd     = rd_strobe && !cpu_wr && !busy;
    // A data read colliding with any write loses, even if the write is itself discarded.
    drop_nxt   = (host_q && busy) || (rd_strobe && (cpu_wr || busy));
    grant_disp = armed_q && disp_req && !(cpu_pend && (starv == 3'd4));
    grant_cpu  = armed_q && cpu_pend && !grant_disp;
    cpu_addr   = op_wr_q ? mawr : marr;
  end

  // CPU engine state register
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_wr || acc_rd) state_d = PEND;
      PEND:    if (grant_cpu) state_d = (op_wr_q || marr[DATA_W-1]) ? IDLE : FLIGHT;
      FLIGHT:  if (tag_p1 == TAG_CPU) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_busy = (state_q != IDLE);
  end

  // Slot issue (p0), tag delay (p1), read-data capture
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      MA         <= '0;
      re         <= 1'b0;
      we         <= 1'b0;
      MD_in      <= '0;
      cpu_rdata  <= '0;
      cpu_drop   <= 1'b0;
      disp_ack   <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      mawr       <= '0;
      marr       <= '0;
      step       <= DATA_W'(1);
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      starv      <= '0;
      tag_p0     <= TAG_NONE;
      tag_p1     <= TAG_NONE;
      armed_q    <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      re         <= 1'b0;
      we         <= 1'b0;
      disp_ack   <= 1'b0;
      disp_valid <= 1'b0;
      cpu_drop   <= drop_nxt;
      tag_p0     <= TAG_NONE;
      tag_p1     <= tag_p0;

      if (grant_disp) begin
        MA       <= disp_addr;
        re       <= 1'b1;
        disp_ack <= 1'b1;
        tag_p0   <= TAG_DISP;
      end else if (grant_cpu) begin
        MA <= cpu_addr;
        if (op_wr_q) begin
          we    <= !mawr[DATA_W-1];
          MD_in <= wdata_q;
          mawr  <= mawr + step;
        end else if (!marr[DATA_W-1]) begin
          re     <= 1'b1;
          tag_p0 <= TAG_CPU;
        end else begin
          cpu_rdata <= '0;
        end
      end

      if (!cpu_pend || grant_cpu) starv <= '0;
      else if (grant_disp)        starv <= starv + 3'd1;

      if (tag_p1 == TAG_DISP) begin
        disp_valid <= 1'b1;
        disp_data  <= MD_out;
      end else if (tag_p1 == TAG_CPU) begin
        cpu_rdata <= MD_out;
      end

      // Host register writes come last so a MAWR load overrides a same-cycle post-write advance.
      if (cpu_wr) begin
        case (cpu_sel)
          SEL_MAWR: mawr <= cpu_wdata;
          SEL_MARR: if (!busy) marr <= cpu_wdata;
          SEL_DATA: if (!busy) wdata_q <= cpu_wdata;
          SEL_INC:  step <= step_decode(cpu_wdata[1:0]);
          default:  ;
        endcase
      end
      if (acc_wr) op_wr_q <= (cpu_sel == SEL_DATA);
      if (acc_rd) begin
        op_wr_q <= 1'b0;
        marr    <= marr + step;
      end
    end
  end

endmodule
